// File: rtl/vivaldi_pkg.sv
// rtl/vivaldi_pkg.sv - shared state encoding and source-index helpers for the waveform crossfader
package vivaldi_pkg;

  typedef enum logic [1:0] {
    SILENT,
    STEADY,
    FADE
  } xfade_state_e;

  // Source indices 0..sources-1 are real channels; index == sources means silence.
  function automatic int idx_width(input int sources);
    return $clog2(sources + 1);
  endfunction

  function automatic int silence_idx(input int sources);
    return sources;
  endfunction

endpackage

// File: rtl/xfade_lerp.sv
// rtl/xfade_lerp.sv - combinational (a*(2^R-k) + b*k) >>> R interpolation of two signed samples
module xfade_lerp #(
  parameter int width_p     = 24,
  parameter int ramp_log2_p = 8
) (
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  input  logic [ramp_log2_p-1:0] k_i,
  output logic [width_p-1:0]     y_o
);

  localparam int iw_lp = width_p + ramp_log2_p + 1;
  localparam logic signed [iw_lp-1:0] full_c = iw_lp'(1) << ramp_log2_p;

  logic signed [iw_lp-1:0] a_x;
  logic signed [iw_lp-1:0] b_x;
  logic signed [iw_lp-1:0] wa;
  logic signed [iw_lp-1:0] wb;
  logic signed [iw_lp-1:0] sum;

  assign a_x = iw_lp'($signed(a_i));
  assign b_x = iw_lp'($signed(b_i));
  assign wb  = iw_lp'(k_i);
  assign wa  = full_c - wb;

  // Weights sum to 2^R, so the result is a convex mix and never exceeds iw_lp.
  assign sum = a_x * wa + b_x * wb;
  assign y_o = width_p'(sum >>> ramp_log2_p);

endmodule

// File: rtl/wave_select_xfade.sv
// rtl/wave_select_xfade.sv - one-hot waveform source select with linear crossfade on every change
module wave_select_xfade
  import vivaldi_pkg::*;
#(
  parameter int width_p     = 24,
  parameter int sources_p   = 5,
  parameter int ramp_log2_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_ni,
  input  logic [sources_p-1:0]         sel_i,
  input  logic [sources_p*width_p-1:0] src_data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [width_p-1:0]           data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         busy_o
);

  localparam int iw_lp = idx_width(sources_p);
  localparam logic [iw_lp-1:0] silence_c = iw_lp'(silence_idx(sources_p));
  localparam logic [ramp_log2_p-1:0] k_last_c = '1;

  xfade_state_e state, state_n;
  logic [iw_lp-1:0] cur, cur_n, nxt, nxt_n, pend, pend_n;
  logic [ramp_log2_p-1:0] k, k_n;
  logic [iw_lp-1:0] hot_idx, target;
  logic onehot, accept;
  logic [width_p-1:0] cur_s, nxt_s, mix;

  always_comb begin
    hot_idx = '0;
    for (int i = 0; i < sources_p; i++) begin
      if (sel_i[i]) hot_idx = iw_lp'(i);
    end
  end

  assign onehot = (sel_i != '0) && ((sel_i & (sel_i - sources_p'(1))) == '0);
  assign target = onehot ? hot_idx : silence_c;

  // The silence index matches no lane, so it contributes zero.
  always_comb begin
    cur_s = '0;
    nxt_s = '0;
    for (int i = 0; i < sources_p; i++) begin
      if (cur == iw_lp'(i)) cur_s = src_data_i[i*width_p +: width_p];
      if (nxt == iw_lp'(i)) nxt_s = src_data_i[i*width_p +: width_p];
    end
  end

  xfade_lerp #(
    .width_p     (width_p),
    .ramp_log2_p (ramp_log2_p)
  ) u_lerp (
    .a_i (cur_s),
    .b_i (nxt_s),
    .k_i (k),
    .y_o (mix)
  );

  assign ready_o = !valid_o || ready_i;
  assign accept  = valid_i && ready_o;
  assign busy_o  = (state == FADE);

  always_comb begin
    state_n = state;
    cur_n   = cur;
    nxt_n   = nxt;
    pend_n  = pend;
    k_n     = k;
    case (state)
      SILENT, STEADY: begin
        if (target != cur) begin
          nxt_n   = target;
          pend_n  = target;
          k_n     = '0;
          state_n = FADE;
        end
      end
      FADE: begin
        pend_n = target;
        if (accept) begin
          if (k == k_last_c) begin
            cur_n = nxt;
            k_n   = '0;
            if (pend != nxt) begin
              nxt_n   = pend;
              state_n = FADE;
            end else begin
              state_n = (nxt == silence_c) ? SILENT : STEADY;
            end
          end else begin
            k_n = k + 1'b1;
          end
        end
      end
      default: state_n = SILENT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state   <= SILENT;
      cur     <= silence_c;
      nxt     <= silence_c;
      pend    <= silence_c;
      k       <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      state <= state_n;
      cur   <= cur_n;
      nxt   <= nxt_n;
      pend  <= pend_n;
      k     <= k_n;
      if (accept) begin
        data_o  <= mix;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/wave_select_xfade.md
WAVE_SELECT_XFADE -- requirements
Module: wave_select_xfade

Interface
REQ-001 Parameter width_p, default 24, signed sample width of every source and of the output.
REQ-002 Parameter sources_p, default 5, number of waveform source channels.
REQ-003 Parameter ramp_log2_p, default 8, crossfade length is 2**ramp_log2_p accepted samples.
REQ-004 clk_i  input  1  single clock, all state on rising edge.
REQ-005 reset_ni  input  1  asynchronous, active-low reset.
REQ-006 sel_i  input  sources_p  one-hot source select, sampled every cycle.
REQ-007 src_data_i  input  sources_p*width_p  packed signed samples, source k at bits [k*width_p +: width_p].
REQ-008 valid_i  input  1  all src_data_i lanes hold a new sample.
REQ-009 ready_o  output  1  block accepts a sample this cycle.
REQ-010 data_o  output  width_p  signed mixed output sample.
REQ-011 valid_o  output  1  data_o holds a sample.
REQ-012 ready_i  input  1  downstream accepts data_o.
REQ-013 busy_o  output  1  crossfade in progress.

Function
REQ-014 Decode sel_i: exactly one bit k set -> target index k; zero bits or more than one bit set -> target SILENCE (contributes 0).
REQ-015 ready_o SHALL equal !valid_o || ready_i; input accepted on valid_i && ready_o; output consumed on valid_o && ready_i.
REQ-016 Latency: accepted sample appears on data_o with valid_o high the next cycle; data_o/valid_o hold stable while valid_o && !ready_i.
REQ-017 States: SILENT (cur=SILENCE), STEADY (cur fixed), FADE (cur -> nxt).
REQ-018 SILENT/STEADY: if decoded target != cur, latch nxt=target, clear ramp counter k=0, enter FADE; else output = cur sample.
REQ-019 FADE output per accepted sample: (cur*(2**ramp_log2_p - k) + nxt*k) >>> ramp_log2_p, arithmetic shift, intermediate width width_p+ramp_log2_p+1 signed, result truncated to width_p (convex sum, no overflow).
REQ-020 k increments by 1 only on accepted samples; when k reaches 2**ramp_log2_p - 1 and a sample is accepted, cur<=nxt, go to STEADY, or SILENT if nxt is SILENCE.
REQ-021 Target change during FADE: fade not aborted; newest target stored as pending (last wins); at fade end, if pending != new cur, start new FADE immediately with k=0.
REQ-022 Target returning to nxt value or cleared pending equal to cur during FADE: no further fade.
REQ-023 No accepted sample -> k, state, data_o unchanged (handshake stall freezes ramp).
REQ-024 busy_o high exactly in FADE.

Reset
REQ-025 reset_ni low SHALL immediately force: state SILENT, cur=nxt=pending=SILENCE, k=0, data_o=0, valid_o=0, busy_o=0.
REQ-026 Reset asserted mid-fade discards the fade; after release, first fade starts from SILENCE.

Structure
REQ-027 Shared package vivaldi_pkg holds the state enum (SILENT, STEADY, FADE) and the SILENCE index constant (sources_p encoding, index width $clog2(sources_p+1)).
REQ-028 One sub-module xfade_lerp: combinational weighted interpolation of two width_p samples by k, parametrised by width_p and ramp_log2_p.

Verification
REQ-029 Reset, sel_i=5'b00001, src0=+1000, ramp_log2_p=2, ready_i=1 -> outputs 0,250,500,750 then 1000 steady, busy_o high for 4 samples.
REQ-030 STEADY on src0=+1000, sel_i->5'b00010 with src1=-1000, ramp 4 -> 1000,500,0,-500,-1000.
REQ-031 sel_i=5'b00011 while STEADY on src0=+800 -> fade to 0 over 4 samples: 800,600,400,200,0, state SILENT.
REQ-032 During fade 0->1, sel_i goes 2 then 3 -> fade 0->1 completes, then single fade 1->3; source 2 never weighted.
REQ-033 ready_i held low 10 cycles mid-fade -> data_o, valid_o, k frozen; fade resumes at same k on release.
REQ-034 reset_ni pulsed low mid-fade, asynchronously between edges -> valid_o=0, data_o=0 before next clock edge.
